adc_scan_ctrl: RTL and testbench

Sequencer for the power module's external multi-channel ADC. It periodically scans CH channels round-robin: selects the channel, pulses conversion start, waits for end-of-conversion with a timeout, and maps each sample to a 0–100 percent value with a saturation flag. One registered result per channel is presented on a single valid-qualified output. It sits between the ADC pins and the power/duty logic that consumes percent values.

---
 rtl/adc_scan_ctrl_pkg.sv | 19 +
 rtl/adc_percent_map.sv | 29 ++
 rtl/adc_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_scan_ctrl_pkg.sv
// Shared types and constants for the ADC scan sequencer.
// Holds the FSM state encoding and the percent scaling defaults.
package adc_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        SELECT,
        START,
        CONV,
        STORE,
        NEXT
    } state_t;

    localparam int PERCENT_FULL  = 100;
    localparam int DEFAULT_DIV   = 4;
    localparam int DEFAULT_RANGE = PERCENT_FULL / DEFAULT_DIV;

endpackage

// File: rtl/adc_percent_map.sv
// Combinational map of a raw ADC sample to 0..100 percent with saturation flag.
// Zero latency; no flow control.
module adc_percent_map
    import adc_scan_ctrl_pkg::*;
#(
    parameter int N   = 8,
    parameter int DIV = DEFAULT_DIV
) (
    input  logic [N-1:0] data,
    output logic [N-1:0] percent,
    output logic         sat
);

    localparam int RANGE = PERCENT_FULL / DIV;
    localparam int PW    = N + $clog2(DIV);

    logic [PW-1:0] prod;

    always_comb begin
        prod    = PW'(data) * PW'(DIV);
        percent = prod[N-1:0];
        sat     = 1'b0;
        if (data > N'(RANGE)) begin
            percent = N'(PERCENT_FULL);
            sat     = 1'b1;
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Periodic round-robin ADC scan: select, start pulse, wait eoc or timeout, publish percent.
// One registered result per channel; ticks arriving mid-scan are dropped and flagged.
module adc_scan_ctrl
    import adc_scan_ctrl_pkg::*;
#(
    parameter int N          = 8,
    parameter int CH         = 4,
    parameter int DIV        = DEFAULT_DIV,
    parameter int SAMPLE_DIV = 1000,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  adc_eoc,
    input  logic [N-1:0]          adc_data,
    output logic [$clog2(CH)-1:0] adc_sel,
    output logic                  adc_start,
    output logic [N-1:0]          percent,
    output logic                  sat,
    output logic [$clog2(CH)-1:0] ch_out,
    output logic                  valid,
    output logic                  timeout_err,
    output logic                  scan_done,
    output logic                  overrun
);

    localparam int SW = $clog2(CH);
    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] LAST_CH = SW'(CH - 1);

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [CW-1:0] conv_cnt;
    logic [SW-1:0] idx;
    logic          tick;
    logic [N-1:0]  map_percent;
    logic          map_sat;

    assign tick    = en && (state != IDLE) && (tick_cnt == TW'(SAMPLE_DIV - 1));
    assign overrun = tick && (state != WAIT_TICK);

    adc_percent_map #(.N(N), .DIV(DIV)) u_map (
        .data    (adc_data),
        .percent (map_percent),
        .sat     (map_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            conv_cnt    <= '0;
            idx         <= '0;
            adc_sel     <= '0;
            adc_start   <= 1'b0;
            percent     <= '0;
            sat         <= 1'b0;
            ch_out      <= '0;
            valid       <= 1'b0;
            timeout_err <= 1'b0;
            scan_done   <= 1'b0;
        end else begin
            adc_start   <= 1'b0;
            valid       <= 1'b0;
            timeout_err <= 1'b0;
            scan_done   <= 1'b0;

            // Free-running sample timer; keeps counting through a scan so overruns are visible.
            if (state == IDLE)
                tick_cnt <= '0;
            else if (en)
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (en)
                        state <= WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (!en) begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                    end else if (tick) begin
                        state   <= SELECT;
                        idx     <= '0;
                        adc_sel <= '0;
                    end
                end
                SELECT: begin
                    adc_start <= 1'b1;
                    state     <= START;
                end
                START: begin
                    conv_cnt <= '0;
                    state    <= CONV;
                end
                CONV: begin
                    if (adc_eoc) begin
                        percent <= map_percent;
                        sat     <= map_sat;
                        ch_out  <= idx;
                        valid   <= 1'b1;
                        state   <= STORE;
                    end else if (conv_cnt == CW'(TIMEOUT - 1)) begin
                        percent     <= '0;
                        sat         <= 1'b1;
                        timeout_err <= 1'b1;
                        ch_out      <= idx;
                        valid       <= 1'b1;
                        state       <= STORE;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                STORE: begin
                    scan_done <= (idx == LAST_CH);
                    state     <= NEXT;
                end
                NEXT: begin
                    // en is only honoured here, so a channel in flight always completes.
                    if (idx == LAST_CH) begin
                        idx   <= '0;
                        state <= en ? WAIT_TICK : IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                        if (en) begin
                            adc_sel <= idx + 1'b1;
                            state   <= SELECT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench: instance a (CH=4, SAMPLE_DIV=40, TIMEOUT=8) covers mapping, timeout,
// en drop and reset; instance b (SAMPLE_DIV=4, slow eoc) covers overrun behaviour.
module tb_adc_scan_ctrl;

    localparam int SD_A = 40;
    localparam int SD_B = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance a
    logic       a_en = 1'b0, a_eoc = 1'b0;
    logic [7:0] a_data = '0;
    logic [1:0] a_sel, a_ch_out;
    logic       a_adc_start, a_sat, a_valid, a_terr, a_scan_done, a_overrun;
    logic [7:0] a_percent;

    adc_scan_ctrl #(.N(8), .CH(4), .DIV(4), .SAMPLE_DIV(SD_A), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .adc_eoc(a_eoc), .adc_data(a_data),
        .adc_sel(a_sel), .adc_start(a_adc_start), .percent(a_percent), .sat(a_sat),
        .ch_out(a_ch_out), .valid(a_valid), .timeout_err(a_terr),
        .scan_done(a_scan_done), .overrun(a_overrun)
    );

    // instance b
    logic       b_en = 1'b0, b_eoc = 1'b0;
    logic [7:0] b_data = '0;
    logic [1:0] b_sel, b_ch_out;
    logic       b_adc_start, b_sat, b_valid, b_terr, b_scan_done, b_overrun;
    logic [7:0] b_percent;

    adc_scan_ctrl #(.N(8), .CH(4), .DIV(4), .SAMPLE_DIV(SD_B), .TIMEOUT(32)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .adc_eoc(b_eoc), .adc_data(b_data),
        .adc_sel(b_sel), .adc_start(b_adc_start), .percent(b_percent), .sat(b_sat),
        .ch_out(b_ch_out), .valid(b_valid), .timeout_err(b_terr),
        .scan_done(b_scan_done), .overrun(b_overrun)
    );

    // ADC models: eoc rises k cycles into CONV (k=0 -> first CONV cycle), one cycle wide.
    int         a_k = 3, a_j = 0, a_starts = 0, a_start_cyc = 0, a_done_cnt = 0;
    logic       a_busy = 1'b0;
    logic [7:0] a_tbl [4] = '{8'd0, 8'd10, 8'd25, 8'd26};
    int         b_k = 20, b_j = 0, b_done = 0, b_ovr = 0;
    logic       b_busy = 1'b0;
    logic [7:0] b_tbl [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic [9:0] b_log [$];

    always @(negedge clk) begin
        if (rst) begin
            a_busy = 1'b0; a_eoc = 1'b0;
        end else if (a_adc_start) begin
            a_busy = 1'b1; a_j = 0; a_eoc = 1'b0; a_starts++; a_start_cyc = cyc;
        end else if (a_busy && a_j == a_k) begin
            a_eoc = 1'b1; a_data = a_tbl[a_sel]; a_busy = 1'b0;
        end else begin
            a_eoc = 1'b0;
            if (a_busy) a_j++;
        end
        if (a_scan_done) a_done_cnt++;
    end

    always @(negedge clk) begin
        if (rst) begin
            b_busy = 1'b0; b_eoc = 1'b0;
        end else if (b_adc_start) begin
            b_busy = 1'b1; b_j = 0; b_eoc = 1'b0;
        end else if (b_busy && b_j == b_k) begin
            b_eoc = 1'b1; b_data = b_tbl[b_sel]; b_busy = 1'b0;
        end else begin
            b_eoc = 1'b0;
            if (b_busy) b_j++;
        end
        if (b_valid) b_log.push_back({b_ch_out, b_percent});
        if (b_overrun) b_ovr++;
        if (b_scan_done) b_done++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid_a(input string tag);
        int n = 0;
        @(negedge clk);
        while (!a_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, int'(a_valid), 1);
    endtask

    task automatic wait_start_a(input string tag);
        int n = 0;
        @(negedge clk);
        while (!a_adc_start && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, int'(a_adc_start), 1);
    endtask

    function automatic int a_outs();
        return int'({a_percent, a_sat, a_ch_out, a_sel, a_adc_start, a_valid,
                     a_terr, a_scan_done, a_overrun});
    endfunction

    int exp_p [4] = '{0, 40, 100, 100};
    int exp_s [4] = '{0, 0, 0, 1};
    int starts, dones, rel, n;

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outs", a_outs(), 0);
        chk("reset_outs_b", int'({b_percent, b_valid, b_adc_start, b_overrun}), 0);

        // Full scan, eoc 3 cycles into CONV.
        rst = 1'b0; a_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid_a($sformatf("scan1_ch%0d", i));
            chk($sformatf("scan1_pct%0d", i), int'(a_percent), exp_p[i]);
            chk($sformatf("scan1_sat%0d", i), int'(a_sat), exp_s[i]);
            chk($sformatf("scan1_ch%0d_id", i), int'(a_ch_out), i);
            chk($sformatf("scan1_terr%0d", i), int'(a_terr), 0);
            chk($sformatf("scan1_lat%0d", i), cyc - a_start_cyc, 5);
            chk($sformatf("scan1_done_early%0d", i), int'(a_scan_done), 0);
        end
        @(negedge clk);
        chk("scan1_done", int'(a_scan_done), 1);
        chk("scan1_pct_hold", int'(a_percent), 100);
        @(negedge clk);
        chk("scan1_done_cnt", a_done_cnt, 1);

        // ch0 never answers; ch1 answers on the final timeout cycle.
        a_k = 1000;
        wait_valid_a("to_ch0");
        chk("to_pct", int'(a_percent), 0);
        chk("to_sat", int'(a_sat), 1);
        chk("to_terr", int'(a_terr), 1);
        chk("to_ch", int'(a_ch_out), 0);
        chk("to_lat", cyc - a_start_cyc, 9);
        a_k = 7; a_tbl[1] = 8'd5;
        wait_valid_a("edge_ch1");
        chk("edge_pct", int'(a_percent), 20);
        chk("edge_sat", int'(a_sat), 0);
        chk("edge_terr", int'(a_terr), 0);
        chk("edge_ch", int'(a_ch_out), 1);
        chk("edge_lat", cyc - a_start_cyc, 9);
        wait_valid_a("edge_ch2");
        wait_valid_a("edge_ch3");
        chk("edge_ch3_sat", int'(a_sat), 1);
        a_k = 3; a_tbl[1] = 8'd10;

        // Drop en while ch1 is converting.
        wait_valid_a("drop_ch0");
        chk("drop_ch0_id", int'(a_ch_out), 0);
        wait_start_a("drop_ch1_start");
        @(negedge clk);
        a_en = 1'b0;
        starts = a_starts; dones = a_done_cnt;
        wait_valid_a("drop_ch1");
        chk("drop_ch1_id", int'(a_ch_out), 1);
        chk("drop_ch1_pct", int'(a_percent), 40);
        repeat (100) @(negedge clk);
        chk("drop_no_start", a_starts, starts);
        chk("drop_no_done", a_done_cnt, dones);

        // Reset while converting, then restart timing.
        a_en = 1'b1;
        wait_start_a("rst_start");
        @(negedge clk);
        chk("pre_rst_pct", int'(a_percent), 40);
        rst = 1'b1;
        #1;
        chk("rst_async_outs", a_outs(), 0);
        @(negedge clk);
        rel = cyc;
        rst = 1'b0;
        wait_start_a("rel_start");
        // first edge after release is rel+1; adc_start is seen SD+1 edges after it
        chk("rel_start_lat", cyc - (rel + 1), SD_A + 1);
        wait_valid_a("rel_ch0");
        chk("rel_ch0_id", int'(a_ch_out), 0);
        chk("rel_ch0_pct", int'(a_percent), 0);
        a_en = 1'b0;

        // Fast tick with slow conversions on instance b.
        b_en = 1'b1;
        n = 0;
        while (b_done < 2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        b_en = 1'b0;
        chk("ovr_scans", b_done, 2);
        chk("ovr_log_len", int'(b_log.size() >= 8), 1);
        chk("ovr_pulsed", int'(b_ovr > 0), 1);
        for (int i = 0; i < 8 && i < b_log.size(); i++) begin
            chk($sformatf("ovr_ch%0d", i), int'(b_log[i][9:8]), i % 4);
            chk($sformatf("ovr_pct%0d", i), int'(b_log[i][7:0]), 4 * (i % 4 + 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
